// File: rtl/skew_fifo_bank_pkg.sv
// skew_fifo_bank_pkg: shared constants and helpers for the skewed FIFO bank.
// Holds the default lane count, depth and data width, so the PE array, the
// operand loader and the bank all agree on them. Also holds the count-width
// helper and the lane-slice macro used to index the packed per-lane buses.

`ifndef SKEW_FIFO_BANK_PKG_SV
`define SKEW_FIFO_BANK_PKG_SV

// Selects lane k of a packed bus whose lanes are w bits wide.
`define SFB_LANE(k, w) ((k) * (w)) +: (w)

package skew_fifo_bank_pkg;

    localparam int unsigned DEF_NUM_CH     = 32;
    localparam int unsigned DEF_DEPTH      = 32;
    localparam int unsigned DEF_DEPTH_LOG2 = 5;
    localparam int unsigned DEF_BWIDTH     = 8;
    localparam int unsigned DEF_AF_LEVEL   = 28;
    localparam bit          DEF_SKEW       = 1'b1;

    // The occupancy counter needs one bit more than a pointer, so it can hold 0..DEPTH.
    function automatic int unsigned count_width(input int unsigned depth_log2);
        return depth_log2 + 1;
    endfunction

endpackage

`endif

// File: rtl/skew_fifo_bank_if.sv
// skew_fifo_bank_if: the push/pop/status bus of the FIFO bank.
// master: the operand loader / array side (drives PUSHE, D_in, POPE, FLUSH, CLR_ERR).
// slave : the bank (drives D_out, D_VALID, IS_EMPTY, IS_FULL, ALMOST_FULL, COUNT, OVF, UDF).
// Lane k of each packed bus occupies bits [k*W +: W].

interface skew_fifo_bank_if #(
    parameter int unsigned NUM_CH     = skew_fifo_bank_pkg::DEF_NUM_CH,
    parameter int unsigned BWIDTH     = skew_fifo_bank_pkg::DEF_BWIDTH,
    parameter int unsigned DEPTH_LOG2 = skew_fifo_bank_pkg::DEF_DEPTH_LOG2
);
    localparam int unsigned CW = skew_fifo_bank_pkg::count_width(DEPTH_LOG2);

    logic [NUM_CH-1:0]        PUSHE;
    logic [NUM_CH*BWIDTH-1:0] D_in;
    logic                     POPE;
    logic                     FLUSH;
    logic                     CLR_ERR;
    logic [NUM_CH*BWIDTH-1:0] D_out;
    logic [NUM_CH-1:0]        D_VALID;
    logic [NUM_CH-1:0]        IS_EMPTY;
    logic [NUM_CH-1:0]        IS_FULL;
    logic [NUM_CH-1:0]        ALMOST_FULL;
    logic [NUM_CH*CW-1:0]     COUNT;
    logic [NUM_CH-1:0]        OVF;
    logic [NUM_CH-1:0]        UDF;

    modport master (
        output PUSHE, D_in, POPE, FLUSH, CLR_ERR,
        input  D_out, D_VALID, IS_EMPTY, IS_FULL, ALMOST_FULL, COUNT, OVF, UDF
    );

    modport slave (
        input  PUSHE, D_in, POPE, FLUSH, CLR_ERR,
        output D_out, D_VALID, IS_EMPTY, IS_FULL, ALMOST_FULL, COUNT, OVF, UDF
    );

endinterface

// File: rtl/skew_fifo_bank_fifo_lane.sv
// fifo_lane: one circular-buffer lane of the bank, with all DEPTH entries usable.
// Ports: CLK, RSTn (sync, active-low), push/d_in (write side), pop_req (read
// command), flush, clr_err; d_out/d_valid (registered pop data); is_empty,
// is_full, almost_full, count (decoded from registers); ovf/udf (sticky errors).

module fifo_lane #(
    parameter int unsigned DEPTH      = skew_fifo_bank_pkg::DEF_DEPTH,
    parameter int unsigned DEPTH_LOG2 = skew_fifo_bank_pkg::DEF_DEPTH_LOG2,
    parameter int unsigned BWIDTH     = skew_fifo_bank_pkg::DEF_BWIDTH,
    parameter int unsigned AF_LEVEL   = skew_fifo_bank_pkg::DEF_AF_LEVEL,
    localparam int unsigned CW        = skew_fifo_bank_pkg::count_width(DEPTH_LOG2)
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              push,
    input  logic [BWIDTH-1:0] d_in,
    input  logic              pop_req,
    input  logic              flush,
    input  logic              clr_err,
    output logic [BWIDTH-1:0] d_out,
    output logic              d_valid,
    output logic              is_empty,
    output logic              is_full,
    output logic              almost_full,
    output logic [CW-1:0]     count,
    output logic              ovf,
    output logic              udf
);

    logic [BWIDTH-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] front;
    logic [DEPTH_LOG2-1:0] rear;
    logic [CW-1:0]         cnt;

    logic empty_c;
    logic full_c;
    logic do_pop_c;
    logic do_push_c;
    logic ovf_set_c;
    logic udf_set_c;

    // Status comes from the registered count only; a same-cycle push never
    // makes an empty lane poppable, and a full lane accepts a push only when
    // it is also popped.
    always_comb begin
        empty_c   = (cnt == '0);
        full_c    = (cnt == CW'(DEPTH));
        do_pop_c  = pop_req & ~empty_c & ~flush;
        do_push_c = push & (~full_c | do_pop_c) & ~flush;
        ovf_set_c = push & full_c & ~do_pop_c & ~flush;
        udf_set_c = pop_req & empty_c & ~flush;
    end

    assign is_empty    = empty_c;
    assign is_full     = full_c;
    assign almost_full = (cnt >= CW'(AF_LEVEL));
    assign count       = cnt;

    // Storage array; contents are don't-care after reset or flush.
    always_ff @(posedge CLK) begin
        if (do_push_c) begin
            mem[rear] <= d_in;
        end
    end

    // Pointers, occupancy, output register and sticky flags.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            front   <= '0;
            rear    <= '0;
            cnt     <= '0;
            d_out   <= '0;
            d_valid <= 1'b0;
            ovf     <= 1'b0;
            udf     <= 1'b0;
        end else begin
            d_valid <= do_pop_c;
            if (do_pop_c) begin
                d_out <= mem[front];
            end
            // A new error in the same cycle as clr_err wins.
            ovf <= (ovf & ~clr_err) | ovf_set_c;
            udf <= (udf & ~clr_err) | udf_set_c;
            if (flush) begin
                front <= '0;
                rear  <= '0;
                cnt   <= '0;
            end else begin
                if (do_pop_c) begin
                    front <= front + DEPTH_LOG2'(1);
                end
                if (do_push_c) begin
                    rear <= rear + DEPTH_LOG2'(1);
                end
                case ({do_push_c, do_pop_c})
                    2'b10:   cnt <= cnt + CW'(1);
                    2'b01:   cnt <= cnt - CW'(1);
                    default: cnt <= cnt;
                endcase
            end
        end
    end

endmodule

// File: rtl/skew_fifo_bank.sv
// skew_fifo_bank: NUM_CH independent FIFO lanes feeding one edge of the PE array.
// With SKEW=1 a single POPE reaches lane k exactly k cycles later, which
// produces the diagonal operand wavefront. With SKEW=0 all lanes pop together.
// Ports: CLK, RSTn (sync, active-low), bus (skew_fifo_bank_if.slave: push/pop
// controls in; data, valid, status and sticky error flags out).

module skew_fifo_bank #(
    parameter int unsigned NUM_CH     = skew_fifo_bank_pkg::DEF_NUM_CH,
    parameter int unsigned DEPTH      = skew_fifo_bank_pkg::DEF_DEPTH,
    parameter int unsigned DEPTH_LOG2 = skew_fifo_bank_pkg::DEF_DEPTH_LOG2,
    parameter int unsigned BWIDTH     = skew_fifo_bank_pkg::DEF_BWIDTH,
    parameter int unsigned AF_LEVEL   = skew_fifo_bank_pkg::DEF_AF_LEVEL,
    parameter bit          SKEW       = skew_fifo_bank_pkg::DEF_SKEW
) (
    input  logic            CLK,
    input  logic            RSTn,
    skew_fifo_bank_if.slave bus
);

    localparam int unsigned CW = skew_fifo_bank_pkg::count_width(DEPTH_LOG2);

    logic [NUM_CH-1:0] pop_req;

    // Skew chain: lane 0 sees POPE directly, and lane k sees it k flops later.
    // Flush and reset kill every pop still travelling down the chain.
    if (SKEW && (NUM_CH > 1)) begin : g_skew
        logic [NUM_CH-2:0] chain;

        always_ff @(posedge CLK) begin
            if (!RSTn || bus.FLUSH) begin
                chain <= '0;
            end else begin
                chain[0] <= bus.POPE;
                for (int k = 1; k < int'(NUM_CH) - 1; k++) begin
                    chain[k] <= chain[k-1];
                end
            end
        end

        assign pop_req = {chain, bus.POPE};
    end else begin : g_flat
        assign pop_req = {NUM_CH{bus.POPE}};
    end

    for (genvar k = 0; k < int'(NUM_CH); k++) begin : g_lane
        fifo_lane #(
            .DEPTH      (DEPTH),
            .DEPTH_LOG2 (DEPTH_LOG2),
            .BWIDTH     (BWIDTH),
            .AF_LEVEL   (AF_LEVEL)
        ) u_lane (
            .CLK         (CLK),
            .RSTn        (RSTn),
            .push        (bus.PUSHE[k]),
            .d_in        (bus.D_in[`SFB_LANE(k, BWIDTH)]),
            .pop_req     (pop_req[k]),
            .flush       (bus.FLUSH),
            .clr_err     (bus.CLR_ERR),
            .d_out       (bus.D_out[`SFB_LANE(k, BWIDTH)]),
            .d_valid     (bus.D_VALID[k]),
            .is_empty    (bus.IS_EMPTY[k]),
            .is_full     (bus.IS_FULL[k]),
            .almost_full (bus.ALMOST_FULL[k]),
            .count       (bus.COUNT[`SFB_LANE(k, CW)]),
            .ovf         (bus.OVF[k]),
            .udf         (bus.UDF[k])
        );
    end

endmodule

// File: tb/tb_skew_fifo_bank.sv
// tb_skew_fifo_bank: self-checking bench for a 4-lane skewed FIFO bank.
// A directed vector table covers reset, the skewed drain and the underflow and
// clear behaviour. Hand sequences cover fill/overflow, the full-lane exchange,
// flush, pointer wrap with almost-full, and a mid-drain reset. A randomized
// phase follows. A queue-based reference model checks every output on every cycle.

module tb_skew_fifo_bank;

    localparam int unsigned NCH = 4;
    localparam int unsigned DEP = 32;
    localparam int unsigned DL2 = 5;
    localparam int unsigned BW  = 8;
    localparam int unsigned AF  = 28;
    localparam int unsigned CW  = DL2 + 1;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    skew_fifo_bank_if #(.NUM_CH(NCH), .BWIDTH(BW), .DEPTH_LOG2(DL2)) bus ();

    skew_fifo_bank #(
        .NUM_CH     (NCH),
        .DEPTH      (DEP),
        .DEPTH_LOG2 (DL2),
        .BWIDTH     (BW),
        .AF_LEVEL   (AF),
        .SKEW       (1'b1)
    ) dut (
        .CLK  (clk),
        .RSTn (rstn),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: one queue of words per lane. A pop command issued in
    // cycle c reaches lane k in cycle c+k, unless a reset or flush happened
    // in or after cycle c.
    typedef logic [7:0] word_q_t[$];
    word_q_t      q [NCH];
    logic [7:0]   m_dout [NCH];
    logic [NCH-1:0] m_dv, m_ovf, m_udf;
    bit           pope_log [int];
    int           cyc = 0;
    int           last_clear = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step(input logic [NCH-1:0] pushe, input logic [31:0] din,
                              input logic pope, input logic flush, input logic clr,
                              input logic rst_n);
        pope_log[cyc] = pope;
        if (!rst_n) begin
            for (int k = 0; k < int'(NCH); k++) begin
                q[k].delete();
                m_dout[k] = 8'h00;
            end
            m_dv = '0; m_ovf = '0; m_udf = '0;
            last_clear = cyc;
        end else if (flush) begin
            for (int k = 0; k < int'(NCH); k++) q[k].delete();
            m_dv = '0;
            if (clr) begin
                m_ovf = '0;
                m_udf = '0;
            end
            last_clear = cyc;
        end else begin
            for (int k = 0; k < int'(NCH); k++) begin
                int  issue;
                bit  req, popped, was_empty, was_full;
                issue     = cyc - k;
                req       = (issue > last_clear) && pope_log.exists(issue) && pope_log[issue];
                was_empty = (q[k].size() == 0);
                was_full  = (q[k].size() == int'(DEP));
                popped    = req && !was_empty;
                if (clr) begin
                    m_ovf[k] = 1'b0;
                    m_udf[k] = 1'b0;
                end
                if (popped) m_dout[k] = q[k].pop_front();
                m_dv[k] = popped;
                if (req && was_empty) m_udf[k] = 1'b1;
                if (pushe[k]) begin
                    if (!was_full || popped) q[k].push_back(din[k*8 +: 8]);
                    else m_ovf[k] = 1'b1;
                end
            end
        end
        cyc++;
    endtask

    task automatic model_check();
        logic [31:0]    e_dout;
        logic [NCH*CW-1:0] e_cnt;
        logic [NCH-1:0] e_empty, e_full, e_af;
        for (int k = 0; k < int'(NCH); k++) begin
            e_dout[k*8 +: 8]   = m_dout[k];
            e_cnt[k*CW +: CW]  = CW'(q[k].size());
            e_empty[k]         = (q[k].size() == 0);
            e_full[k]          = (q[k].size() == int'(DEP));
            e_af[k]            = (q[k].size() >= int'(AF));
        end
        chk("model_d_valid", 64'(bus.D_VALID), 64'(m_dv));
        chk("model_d_out", 64'(bus.D_out), 64'(e_dout));
        chk("model_count", 64'(bus.COUNT), 64'(e_cnt));
        chk("model_is_empty", 64'(bus.IS_EMPTY), 64'(e_empty));
        chk("model_is_full", 64'(bus.IS_FULL), 64'(e_full));
        chk("model_almost_full", 64'(bus.ALMOST_FULL), 64'(e_af));
        chk("model_ovf", 64'(bus.OVF), 64'(m_ovf));
        chk("model_udf", 64'(bus.UDF), 64'(m_udf));
    endtask

    // One clock: drive inputs, take the edge, advance the model, compare 1 ns later.
    task automatic cycle(input logic [NCH-1:0] pushe, input logic [31:0] din,
                         input logic pope, input logic flush, input logic clr,
                         input logic rst_n);
        bus.PUSHE   = pushe;
        bus.D_in    = din;
        bus.POPE    = pope;
        bus.FLUSH   = flush;
        bus.CLR_ERR = clr;
        rstn        = rst_n;
        @(posedge clk);
        model_step(pushe, din, pope, flush, clr, rst_n);
        #1;
        model_check();
    endtask

    task automatic idle();
        cycle('0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    typedef struct {
        logic           rst_n;
        logic           flush;
        logic           clr;
        logic           pope;
        logic [NCH-1:0] pushe;
        logic [31:0]    din;
        logic [NCH-1:0] dv;
        logic [NCH-1:0] empty;
        logic [NCH-1:0] udf;
        logic [31:0]    dout;
    } vec_t;

    vec_t tbl [11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NCH-1:0] pp;

        //             rst flush clr pope pushe din            dv     empty  udf    dout
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h00000000, 4'h0, 4'hF, 4'h0, 32'h00000000};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 32'hA3A2A1A0, 4'h0, 4'h0, 4'h0, 32'h00000000};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 32'h00000000, 4'h1, 4'h1, 4'h0, 32'h000000A0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h00000000, 4'h2, 4'h3, 4'h0, 32'h0000A1A0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h00000000, 4'h4, 4'h7, 4'h0, 32'h00A2A1A0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h00000000, 4'h8, 4'hF, 4'h0, 32'hA3A2A1A0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 32'h00000000, 4'h0, 4'hF, 4'h1, 32'hA3A2A1A0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h00000000, 4'h0, 4'hF, 4'h3, 32'hA3A2A1A0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h4, 32'h00770000, 4'h0, 4'hB, 4'h7, 32'hA3A2A1A0};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 32'h00000000, 4'h0, 4'hB, 4'h8, 32'hA3A2A1A0};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 32'h00000000, 4'h0, 4'hB, 4'h0, 32'hA3A2A1A0};

        for (int i = 0; i < 11; i++) begin
            cycle(tbl[i].pushe, tbl[i].din, tbl[i].pope, tbl[i].flush, tbl[i].clr, tbl[i].rst_n);
            chk($sformatf("tbl%0d_d_valid", i), 64'(bus.D_VALID), 64'(tbl[i].dv));
            chk($sformatf("tbl%0d_is_empty", i), 64'(bus.IS_EMPTY), 64'(tbl[i].empty));
            chk($sformatf("tbl%0d_udf", i), 64'(bus.UDF), 64'(tbl[i].udf));
            chk($sformatf("tbl%0d_d_out", i), 64'(bus.D_out), 64'(tbl[i].dout));
        end

        // Fill lane 0 to the brim, then overflow it.
        cycle('0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("flush_count", 64'(bus.COUNT), 64'h0);
        for (int i = 1; i <= 32; i++) cycle(4'h1, 32'(i), 1'b0, 1'b0, 1'b0, 1'b1);
        chk("fill_is_full0", 64'(bus.IS_FULL[0]), 64'h1);
        chk("fill_count0", 64'(bus.COUNT[0 +: CW]), 64'd32);
        cycle(4'h1, 32'h21, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovf_set0", 64'(bus.OVF[0]), 64'h1);
        chk("ovf_count0", 64'(bus.COUNT[0 +: CW]), 64'd32);
        cycle('0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("ovf_cleared0", 64'(bus.OVF[0]), 64'h0);

        // Push into a full lane while it is popped in the same cycle.
        cycle(4'h1, 32'h55, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("xchg_count0", 64'(bus.COUNT[0 +: CW]), 64'd32);
        chk("xchg_no_ovf0", 64'(bus.OVF[0]), 64'h0);
        chk("xchg_dout0", 64'(bus.D_out[7:0]), 64'h01);
        for (int i = 0; i < 32; i++) begin
            cycle('0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
            if (i == 31) chk("xchg_55_out", 64'(bus.D_out[7:0]), 64'h55);
        end
        for (int i = 0; i < 3; i++) idle();

        // Flush keeps the sticky flags but empties every lane.
        cycle('0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("flush_udf_kept", 64'(bus.UDF), 64'hE);
        chk("flush_count_zero", 64'(bus.COUNT), 64'h0);
        chk("flush_no_dvalid", 64'(bus.D_VALID), 64'h0);

        // Pointer wrap on lane 1 and the almost-full threshold.
        for (int i = 0; i < 30; i++) begin
            cycle(4'h2, 32'((8'h40 + 8'(i)) << 8), 1'b0, 1'b0, 1'b0, 1'b1);
            chk($sformatf("af_rise_%0d", i + 1), 64'(bus.ALMOST_FULL[1]), 64'((i + 1) >= int'(AF)));
        end
        for (int i = 0; i < 30; i++) cycle('0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle();
        chk("wrap_drained", 64'(bus.COUNT[CW +: CW]), 64'h0);
        for (int i = 0; i < 30; i++) cycle(4'h2, 32'((8'h80 + 8'(i)) << 8), 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 30; i++) cycle('0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) idle();
        chk("wrap_last_word", 64'(bus.D_out[15:8]), 64'h9D);

        // Reset in the middle of a skewed drain.
        cycle(4'hF, 32'h0D0C0B0A, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle('0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle();
        cycle('0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_d_valid", 64'(bus.D_VALID), 64'h0);
        chk("rst_d_out", 64'(bus.D_out), 64'h0);
        chk("rst_count", 64'(bus.COUNT), 64'h0);
        chk("rst_is_empty", 64'(bus.IS_EMPTY), 64'hF);
        chk("rst_flags", 64'({bus.OVF, bus.UDF, bus.IS_FULL, bus.ALMOST_FULL}), 64'h0);
        for (int i = 0; i < 4; i++) begin
            idle();
            chk("rst_no_late_valid", 64'(bus.D_VALID), 64'h0);
        end

        // Randomized traffic with a shifting push/pop balance.
        for (int i = 0; i < 800; i++) begin
            int push_pct;
            int pop_pct;
            push_pct = ((i / 100) % 2 == 0) ? 75 : 30;
            pop_pct  = ((i / 100) % 2 == 0) ? 35 : 80;
            for (int k = 0; k < int'(NCH); k++) pp[k] = ($urandom_range(0, 99) < push_pct);
            cycle(pp, $urandom,
                  $urandom_range(0, 99) < pop_pct,
                  $urandom_range(0, 99) == 0,
                  $urandom_range(0, 15) == 0,
                  $urandom_range(0, 299) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/skew_fifo_bank.md
# skew_fifo_bank

Parametrised bank of NUM_CH independent synchronous FIFOs that feed one edge of the systolic PE array. It generalises the single-lane FIFO in three ways: all DEPTH entries are usable, each lane reports occupancy and almost-full, and lanes can be popped with a built-in diagonal skew. In skew mode one pop command reaches lane k exactly k cycles later, which produces the staggered operand wavefront the array needs without external delay lines. The bank sits between the operand loader (push side) and the array row/column inputs (pop side).

## Interface
- NUM_CH, 32: number of lanes (one per PE row/column).
- DEPTH, 32: entries per lane; must be a power of two.
- DEPTH_LOG2, 5: log2(DEPTH).
- BWIDTH, 8: data width per lane.
- AF_LEVEL, 28: ALMOST_FULL[k] asserts when COUNT_k >= AF_LEVEL.
- SKEW, 1: 1 = lane k pop delayed k cycles; 0 = all lanes pop together.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RSTn  in  1  reset, synchronous, active-low.
- PUSHE  in  NUM_CH  per-lane push enable.
- D_in  in  NUM_CH*BWIDTH  push data; lane k occupies bits [k*BWIDTH +: BWIDTH].
- POPE  in  1  pop command, fanned out through the skew chain.
- FLUSH  in  1  synchronous clear of all lanes.
- CLR_ERR  in  1  clears the sticky error flags.
- D_out  out  NUM_CH*BWIDTH  registered pop data, packed the same way as D_in.
- D_VALID  out  NUM_CH  D_out lane k holds a popped word this cycle.
- IS_EMPTY, IS_FULL, ALMOST_FULL  out  NUM_CH each  per-lane status.
- COUNT  out  NUM_CH*(DEPTH_LOG2+1)  per-lane occupancy, 0..DEPTH.
- OVF, UDF  out  NUM_CH each  sticky overflow and underflow flags.

## Operation
- Each lane is a circular buffer with a front pointer, a rear pointer (DEPTH_LOG2 bits, natural wrap) and a count register (DEPTH_LOG2+1 bits).
  - IS_EMPTY = (count == 0).
  - IS_FULL = (count == DEPTH).
- Pop request to lane k:
  - SKEW=1: pop_req[0] = POPE; pop_req[k] = pop_req[k-1] delayed one cycle (shift chain of NUM_CH-1 flops).
  - SKEW=0: pop_req[k] = POPE for every lane.
- Pop, when pop_req[k] is high and the lane is not empty:
  - D_out_k <= data[front]; D_VALID_k <= 1; front advances; count decrements.
- Pop on an empty lane: no pointer change; D_VALID_k <= 0; UDF_k sets.
- Push, when PUSHE[k] is high and the lane is not full, or is full with a pop on the same lane in the same cycle:
  - data[rear] <= D_in_k; rear advances; count increments.
- Push rejected (full and no pop that cycle): data is dropped; OVF_k sets.
- Simultaneous push and pop on one lane: count unchanged; both pointers advance.
- Status is always sampled at the start of the cycle; there is no bypass. Push and pop on an empty lane in the same cycle gives an underflow, and the pushed word is stored.
- FLUSH (RSTn high): pointers, counts, skew chain and D_VALID clear. Push and pop in that cycle are ignored. OVF/UDF are kept; memory contents are don't-care.
- CLR_ERR clears OVF/UDF. If a new error occurs in the same cycle, that error's set wins.
- D_out holds its last value whenever D_VALID is 0.

## Timing
- Reset (RSTn low at a rising edge), regardless of activity in flight:
  - D_out, D_VALID, COUNT, IS_FULL, ALMOST_FULL, OVF, UDF, skew chain: 0.
  - IS_EMPTY: all 1.
- Pop latency: POPE high in cycle t gives D_VALID_k in cycle t+1+k (SKEW=1) or t+1 (SKEW=0).
- Push-to-pop: a word pushed in cycle t can be popped by a pop_req in cycle t+1 at the earliest.
- IS_EMPTY, IS_FULL, ALMOST_FULL and COUNT change the cycle after the causing edge; they are decoded combinationally from registers.
- Throughput: one push and one pop per lane per cycle, sustained.

## Structure
- Shared package/header: the count-width helper (DEPTH_LOG2+1) and the lane-slice macro for packed buses. Default NUM_CH/DEPTH/BWIDTH constants live there as well, so the PE array and the loader use the same values.
- Sub-module fifo_lane: one buffer with count, status, registered output and sticky flags.
- Top level: the skew chain plus a generate loop of NUM_CH fifo_lane instances.

## Test plan
- Fill: after reset, push lane 0 with 0x01..0x20 (32 words) → IS_FULL[0]=1 and COUNT_0=32. A 33rd push → dropped, OVF[0]=1, COUNT_0=32.
- Skew drain: NUM_CH=4, SKEW=1, each lane preloaded with 0xA0+k; pulse POPE in cycle t → D_VALID[k] in cycle t+1+k with D_out_k=0xA0+k, and no other D_VALID bits high.
- Full-lane exchange: lane full, PUSHE and pop_req in the same cycle with D_in=0x55 → COUNT stays 32, no OVF, and 0x55 emerges after 31 further pops.
- Empty-lane pop: POPE while lane 2 is empty and pushed in the same cycle → UDF[2]=1, D_VALID[2]=0, COUNT_2=1. CLR_ERR → UDF[2]=0.
- Wrap and almost-full: push 30 words, pop 30, push 30 again → data order preserved across the pointer wrap. ALMOST_FULL rises exactly when COUNT reaches 28.
- Mid-operation reset and flush: RSTn low during a skewed drain → all outputs return to reset values in the next cycle and no late D_VALID appears. FLUSH → COUNT=0 and OVF/UDF unchanged.
